// File: rtl/ALU_REGFILE_defs.sv
// Shared definitions for the ALU / register-file datapath and its writeback sequencer.
package ALU_REGFILE_defs;

    localparam int REGFILE_ADDR_WIDTH = 3;
    localparam int REGFILE_WIDTH      = 16;
    localparam int ALU_INPUT_WIDTH    = 8;
    localparam int ALU_OUTPUT_WIDTH   = 8;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOT,
        ALU_SHL,
        ALU_SHR
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WRITE
    } seq_state_t;

endpackage

// File: rtl/alu_wb_sequencer.sv
// Issue/writeback controller: takes one reg-to-reg op per handshake, steers the register
// file reads and ALU controls, captures ALU_Out and writes the extended result back.
module alu_wb_sequencer
    import ALU_REGFILE_defs::*;
#(
    parameter int RD_LAT   = 1,
    parameter bit SIGN_EXT = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic                          Clock,
    input  logic                          Reset_N,
    input  logic                          Instr_Valid,
    output logic                          Instr_Ready,
    input  aluop_t                        Instr_Opcode,
    input  logic                          Instr_Carry,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Src1,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Src2,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Instr_Dst,
    output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1,
    output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_2,
    output aluop_t                        Opcode,
    output logic                          Carry_In,
    input  logic [ALU_OUTPUT_WIDTH-1:0]   ALU_Out,
    output logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr,
    output logic                          Write_enable,
    output logic [REGFILE_WIDTH-1:0]      Write_data,
    output logic                          Done,
    output logic [CNT_W-1:0]              Retired_Count
);

    seq_state_t                    state;
    logic [2:0]                    wait_cnt;
    logic [REGFILE_ADDR_WIDTH-1:0] dst_p0;

    // A size cast of a signed value sign-extends, of an unsigned value zero-extends,
    // and truncates to the LSBs when the ALU result is at least as wide as a register.
    function automatic logic [REGFILE_WIDTH-1:0] extend_result(
        input logic [ALU_OUTPUT_WIDTH-1:0] raw
    );
        logic signed [ALU_OUTPUT_WIDTH-1:0] raw_s;
        raw_s = $signed(raw);
        if (SIGN_EXT)
            return REGFILE_WIDTH'(raw_s);
        return REGFILE_WIDTH'(raw);
    endfunction

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            dst_p0        <= '0;
            Instr_Ready   <= 1'b1;
            Read_Addr_1   <= '0;
            Read_Addr_2   <= '0;
            Opcode        <= ALU_ADD;
            Carry_In      <= 1'b0;
            Write_Addr    <= '0;
            Write_enable  <= 1'b0;
            Write_data    <= '0;
            Done          <= 1'b0;
            Retired_Count <= '0;
        end else begin
            Write_enable <= 1'b0;
            Done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (Instr_Valid && Instr_Ready) begin
                        Read_Addr_1 <= Instr_Src1;
                        Read_Addr_2 <= Instr_Src2;
                        Opcode      <= Instr_Opcode;
                        Carry_In    <= Instr_Carry;
                        dst_p0      <= Instr_Dst;
                        wait_cnt    <= 3'(RD_LAT);
                        Instr_Ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1)
                        state <= EXEC;
                end
                // EXEC -> WRITE edge: ALU_Out is captured and the writeback pulse launched.
                EXEC: begin
                    Write_data    <= extend_result(ALU_Out);
                    Write_Addr    <= dst_p0;
                    Write_enable  <= 1'b1;
                    Done          <= 1'b1;
                    Retired_Count <= Retired_Count + CNT_W'(1);
                    state         <= WRITE;
                end
                WRITE: begin
                    Instr_Ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    Instr_Ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
